// File: rtl/wave_rebuild_pkg.sv
// Shared constants and types for the wave rebuild sample path.
package wave_rebuild_pkg;
  localparam int ACC_W_DEF  = 22;
  localparam int DATA_W_DEF = 8;
  localparam int PH_MSB     = 20;
  localparam int PH_LSB     = 10;
  localparam int SIGN_BIT   = 21;

  typedef logic signed [DATA_W_DEF:0] sample_t;

  typedef struct packed {
    logic vld;
    logic sign;
  } flag_t;
endpackage

// File: rtl/wave_rebuild_lat_pipe.sv
// DEPTH-deep {valid, sign} shift register that tracks a fixed read latency.
module lat_pipe
  import wave_rebuild_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  flag_t d,
  output flag_t q
);
  flag_t [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign q = vld_pipe[DEPTH-1];
endmodule

// File: rtl/wave_rebuild.sv
// Phase accumulator plus sign restore for the folded sine ROM.
// Build option WAVE_REBUILD_PHASE_RESET_EN: tune_load also zeroes the phase.
module wave_rebuild
  import wave_rebuild_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic                enable,
  input  logic                tune_load,
  input  logic [ACC_W-1:0]    tune_word,
  output logic [10:0]         phase_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic signed [DATA_W:0] sample,
  output logic                sample_valid
);
  logic [ACC_W-1:0] acc, inc, acc_sum;
  logic             clr, launch;
  flag_t            iss, rom_flag;
  logic [DATA_W:0]  mag;

`ifdef WAVE_REBUILD_PHASE_RESET_EN
  assign clr = tune_load;
`else
  assign clr = 1'b0;
`endif

  assign acc_sum = acc + inc;
  assign launch  = sample_tick & enable & ~clr;

  // inc is read before it is reloaded, so a coincident tick uses the old pitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      inc <= '0;
      iss <= '0;
    end else begin
      if (tune_load) inc <= tune_word;
      if (clr)         acc <= '0;
      else if (launch) acc <= acc_sum;
      iss <= '{vld: launch, sign: acc_sum[SIGN_BIT]};
    end
  end

  assign phase_addr = acc[PH_MSB:PH_LSB];

  // iss lines up with phase_addr; the pipe then covers the ROM read
  lat_pipe #(.DEPTH(ROM_LAT)) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (iss),
    .q     (rom_flag)
  );

  assign mag = {1'b0, rom_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= rom_flag.vld;
      if (rom_flag.vld) sample <= rom_flag.sign ? $signed(-mag) : $signed(mag);
    end
  end
endmodule

// File: tb/tb_wave_rebuild.sv
// Directed bench: ROM_LAT=1 and ROM_LAT=3 instances share one stimulus.
module tb_wave_rebuild;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic              enable = 1'b0;
  logic              tune_load = 1'b0;
  logic [21:0]       tune_word = '0;
  logic [10:0]       pa1, pa3;
  logic [7:0]        rom1 = '0, r3a = '0, r3b = '0, r3c = '0;
  logic signed [8:0] s1, s3;
  logic              v1, v3;
  logic              rom_mode = 1'b0;
  logic [7:0]        rom_const = '0;
  int                n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  wave_rebuild #(.ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .enable(enable),
    .tune_load(tune_load), .tune_word(tune_word), .phase_addr(pa1),
    .rom_data(rom1), .sample(s1), .sample_valid(v1));

  wave_rebuild #(.ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .enable(enable),
    .tune_load(tune_load), .tune_word(tune_word), .phase_addr(pa3),
    .rom_data(r3c), .sample(s3), .sample_valid(v3));

  function automatic logic [7:0] rom_f(input logic [10:0] a, input logic m,
                                       input logic [7:0] c);
    return m ? c : a[7:0];
  endfunction

  always @(posedge clk) begin
    rom1 <= rom_f(pa1, rom_mode, rom_const);
    r3a  <= rom_f(pa3, rom_mode, rom_const);
    r3b  <= r3a;
    r3c  <= r3b;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load(input logic [21:0] w);
    tune_load = 1'b1;
    tune_word = w;
    step();
    tune_load = 1'b0;
  endtask

  // single tick, returns in the cycle its sample is visible on the LAT=1 dut
  task automatic do_tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    // reset state
    step(); step();
    chk("rst_pa", int'(pa1), 0);
    chk("rst_s", int'(s1), 0);
    chk("rst_v", int'(v1), 0);
    rst_n = 1'b1;
    step();

    // ramp: inc=1024, five back-to-back ticks
    load(22'd1024);
    enable = 1'b1;
    sample_tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("ramp_pa%0d", k), int'(pa1), (k <= 5) ? k : 5);
      chk($sformatf("ramp_v%0d", k), int'(v1), (k >= 3 && k <= 7) ? 1 : 0);
      chk($sformatf("ramp_s%0d", k), int'(s1), (k < 3) ? 0 : ((k - 2 > 5) ? 5 : k - 2));
      if (k == 5) sample_tick = 1'b0;
    end

    // reset with two flags in flight
    sample_tick = 1'b1;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pa", int'(pa1), 0);
    chk("mid_rst_s", int'(s1), 0);
    chk("mid_rst_v", int'(v1), 0);
    sample_tick = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("post_rst_v%0d", k), int'(v1), 0);
    end

    // sign alternation: inc=2^21, constant magnitude 100
    rom_mode = 1'b1;
    rom_const = 8'd100;
    load(22'h200000);
    sample_tick = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) sample_tick = 1'b0;
      if (k >= 3) begin
        chk($sformatf("sign_v%0d", k), int'(v1), 1);
        chk($sformatf("sign_s%0d", k), int'(s1), (k % 2 == 1) ? -100 : 100);
      end
    end

    // wrap and extremes
    reset_dut();
    rom_mode = 1'b0;
    load(22'h3FFC00);
    do_tick();
    chk("ext_pa", int'(pa1), 11'h7FF);
    chk("ext_v", int'(v1), 1);
    chk("ext_neg255", int'(s1), -255);
    chk("ext_code", int'($unsigned(s1)), 9'h101);
    rom_mode = 1'b1;
    rom_const = 8'd200;
    load(22'd1024);
    do_tick();
    chk("wrap_pos", int'(s1), 200);
    rom_mode = 1'b0;
    load(22'h200000);
    do_tick();
    chk("negzero_pa", int'(pa1), 0);
    chk("negzero_v", int'(v1), 1);
    chk("negzero_s", int'(s1), 0);

    // tune_load coincident with tick
    reset_dut();
    load(22'd1024);
    do_tick();
    chk("co_pa0", int'(pa1), 1);
    tune_load = 1'b1;
    tune_word = 22'd2048;
    sample_tick = 1'b1;
    step();
    tune_load = 1'b0;
    sample_tick = 1'b0;
`ifdef WAVE_REBUILD_PHASE_RESET_EN
    chk("co_pa1", int'(pa1), 0);
    step(); step();
    chk("co_v1", int'(v1), 0);
    do_tick();
    chk("co_pa2", int'(pa1), 2);
`else
    chk("co_pa1", int'(pa1), 2);
    step(); step();
    chk("co_v1", int'(v1), 1);
    chk("co_s1", int'(s1), 2);
    do_tick();
    chk("co_pa2", int'(pa1), 4);
`endif

    // zero increment: every tick gives the same sample
    reset_dut();
    rom_mode = 1'b1;
    rom_const = 8'd77;
    sample_tick = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 3) sample_tick = 1'b0;
      if (k >= 3) begin
        chk($sformatf("zero_v%0d", k), int'(v1), 1);
        chk($sformatf("zero_s%0d", k), int'(s1), 77);
      end
    end
    step();
    chk("zero_vend", int'(v1), 0);

    // enable drop with ROM_LAT=3: in-flight sample lands 5 cycles after tick
    reset_dut();
    rom_mode = 1'b0;
    load(22'd1024);
    sample_tick = 1'b1;
    step();
    chk("en_v3_1", int'(v3), 0);
    sample_tick = 1'b0;
    step();
    chk("en_v3_2", int'(v3), 0);
    enable = 1'b0;
    sample_tick = 1'b1;
    for (int k = 3; k <= 9; k++) begin
      step();
      chk($sformatf("en_v3_%0d", k), int'(v3), (k == 5) ? 1 : 0);
      if (k == 5) chk("en_s3", int'(s3), 1);
    end
    chk("en_pa3_hold", int'(pa3), 1);
    chk("en_s3_hold", int'(s3), 1);
    sample_tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
